// File: rtl/dbus_ram_responder.sv
// Word-addressed 64-bit SRAM responder for the dbus request/response handshake with a fixed access latency.
// Define DBUS_RAM_RAND_DELAY_EN to add 0..3 LFSR-chosen extra cycles per access.

typedef enum logic [2:0] {
  MSIZE1,
  MSIZE2,
  MSIZE4,
  MSIZE8
} msize_t;

typedef struct packed {
  logic        valid;
  logic [63:0] addr;
  msize_t      size;
  logic [7:0]  strobe;
  logic [63:0] data;
} dbus_req_t;

typedef struct packed {
  logic        addr_ok;
  logic        data_ok;
  logic [63:0] data;
} dbus_resp_t;

module dbus_ram_responder #(
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic       clk,
  input  logic       rst,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [4:0] LAT_M1 = 5'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state_reg, state_next;
  logic [4:0]    cnt_reg, cnt_next;
  logic [4:0]    extra;
  logic [4:0]    wait_cycles;
  logic          accept;
  logic          enter_resp;

  logic [AW-1:0] idx_reg;
  logic [7:0]    strobe_reg;
  logic [63:0]   wdata_reg;

  logic          addr_ok_reg;
  logic          data_ok_reg;
  logic [63:0]   rdata_reg;

  logic [AW-1:0] req_idx;
  logic [AW-1:0] rd_idx;
  logic [7:0]    rd_strobe;
  logic          wr_en;
  logic [7:0]    byte_we;

  logic [63:0]   mem [DEPTH];

  assign req_idx = dreq.addr[3 +: AW];

  // Upper address bits alias, low bits and size are irrelevant: byte lanes come from strobe.
  logic unused_req;
  assign unused_req = ^{dreq.size, dreq.addr[63:AW+3], dreq.addr[2:0]};

`ifdef DBUS_RAM_RAND_DELAY_EN
  logic [7:0] lfsr_reg;

  always_ff @(posedge clk) begin
    if (rst) lfsr_reg <= 8'hA5;
    else     lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
  end

  assign extra = {3'b000, lfsr_reg[1:0]};
`else
  assign extra = 5'd0;
`endif

  // Number of WAIT cycles between acceptance and the response cycle.
  assign wait_cycles = LAT_M1 + extra;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (dreq.valid) begin
          accept = 1'b1;
          if (wait_cycles == 5'd0) begin
            state_next = RESP;
            enter_resp = 1'b1;
            cnt_next   = 5'd0;
          end else begin
            state_next = WAIT;
            cnt_next   = wait_cycles;
          end
        end
      end
      WAIT: begin
        if (!dreq.valid) begin
          state_next = IDLE;
          cnt_next   = 5'd0;
        end else if (cnt_reg <= 5'd1) begin
          state_next = RESP;
          enter_resp = 1'b1;
          cnt_next   = 5'd0;
        end else begin
          cnt_next = cnt_reg - 5'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= 5'd0;
      addr_ok_reg <= 1'b0;
      data_ok_reg <= 1'b0;
      rdata_reg   <= 64'd0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      addr_ok_reg <= enter_resp;
      data_ok_reg <= enter_resp;
      if (enter_resp && (rd_strobe == 8'd0)) rdata_reg <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_reg    <= req_idx;
      strobe_reg <= dreq.strobe;
      wdata_reg  <= dreq.data;
    end
  end

  // Zero-wait accesses are read in the same cycle they are accepted, before the latch lands.
  assign rd_idx    = accept ? req_idx : idx_reg;
  assign rd_strobe = accept ? dreq.strobe : strobe_reg;

  // Write commits at the end of the response cycle, so the read above sees the old dword.
  assign wr_en = (state_reg == RESP) && !rst;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_byte_we
      assign byte_we[gi] = wr_en & strobe_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (byte_we[b]) mem[idx_reg][8*b +: 8] <= wdata_reg[8*b +: 8];
    end
  end

  assign dresp = {addr_ok_reg, data_ok_reg, rdata_reg};

endmodule
